pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/redirect controller for the RV32IM 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the fetch stage's stall, flush, PC-select and target inputs, plus the ID/EX bubble control.
- Resolves hazards by fixed priority:
  - branch/jump redirect
  - multi-cycle mul/div occupancy
  - load-use dependency
  - external halt
- Registered FSM with combinational hazard outputs.

Parameters:
- DWIDTH, 32, PC/target width.
- MD_TIMEOUT, 64, maximum MD_WAIT cycles before forced exit; valid range 2..255.

Ports:
- Clk_Core  input  1  core clock.
- Rst_Core  input  1  synchronous active-high reset.
- id_rs1_fi  input  5  ID-stage rs1 index.
- id_rs2_fi  input  5  ID-stage rs2 index.
- id_rs1_used_fi  input  1  ID instruction reads rs1.
- id_rs2_used_fi  input  1  ID instruction reads rs2.
- ex_rd_fi  input  5  EX-stage destination index.
- ex_mem_read_fi  input  1  EX instruction is a load.
- ex_branch_taken_fi  input  1  EX resolved a taken branch or jump.
- ex_target_fi  input  DWIDTH  redirect target PC.
- ex_md_start_fi  input  1  EX issued a multi-cycle mul/div.
- md_done_fi  input  1  mul/div result valid.
- halt_req_fi  input  1  external halt/debug request, level.
- stall_if_fo  output  1  hold fetch registers and PC.
- flush_if_fo  output  1  fetch loads NOP (0x0000_0013).
- pc_sel_fo  output  1  select redirect target.
- pc_imm_fo  output  DWIDTH  redirect target.
- stall_id_fo  output  1  hold IF/ID-decode registers.
- bubble_ex_fo  output  1  insert NOP into ID/EX.
- md_timeout_fo  output  1  one-cycle pulse on timeout.
- halted_fo  output  1  pipeline in HALT.

Behaviour:

States and reset:
- FSM states: RUN, MD_WAIT, HALT.
- Reset (sampled on Clk_Core edge, overrides all): state=RUN, md counter=0.
- All outputs are 0 during and immediately after reset; pc_imm_fo=0.

Load-use hazard (combinational):
- lu = ex_mem_read_fi & (ex_rd_fi!=0) & ((id_rs1_used_fi & id_rs1_fi==ex_rd_fi) | (id_rs2_used_fi & id_rs2_fi==ex_rd_fi)).

RUN outputs, highest priority first:
1. ex_branch_taken_fi:
   - pc_sel_fo=1, pc_imm_fo=ex_target_fi, flush_if_fo=1, bubble_ex_fo=1.
   - stall_if_fo=0, stall_id_fo=0. The redirect overrides lu.
2. ex_md_start_fi:
   - stall_if_fo=1, stall_id_fo=1.
   - Next state MD_WAIT; counter cleared to 0.
   - If md_done_fi is also 1 this cycle, no stall and remain in RUN.
3. lu:
   - stall_if_fo=1, stall_id_fo=1, bubble_ex_fo=1, for exactly one cycle per hazard.
4. halt_req_fi:
   - stall_if_fo=1, stall_id_fo=1, bubble_ex_fo=1; next state HALT.

Invariants:
- stall_if_fo and flush_if_fo are never both 1. Fetch gives stall priority, so this is required.
- pc_sel_fo=1 implies flush_if_fo=1.
- pc_imm_fo=0 whenever pc_sel_fo=0.

MD_WAIT:
- stall_if_fo=1, stall_id_fo=1, bubble_ex_fo=0; all EX inputs ignored.
- Counter increments each cycle.
- md_done_fi=1: outputs deassert in the same cycle; next state RUN.
- Counter reaches MD_TIMEOUT-1 without done:
  - md_timeout_fo pulses 1 cycle, stalls deassert in the same cycle, next state RUN.
  - No auto-redirect.
- Counter width: clog2(MD_TIMEOUT)+1; no wrap.

HALT:
- stall_if_fo=1, stall_id_fo=1, bubble_ex_fo=1, halted_fo=1.
- Exit to RUN the cycle after halt_req_fi=0; stalls release that same cycle.
- halted_fo is registered from the state (1 only while state=HALT).

Simultaneous-event and boundary cases:
- halt_req_fi during MD_WAIT is deferred until MD_WAIT exits, then evaluated in RUN.
- Redirect in the same cycle as halt_req_fi: redirect is taken and the next state is HALT. The flush completes before the freeze.
- Reset mid-MD_WAIT or mid-HALT returns to RUN with no timeout pulse.

Optional Feature:
- Macro PIPE_HAZARD_CTRL_PERF_EN.
- When defined, adds three outputs, all cleared by reset:
  - perf_stall_cnt_fo (32), counting cycles with stall_if_fo=1.
  - perf_flush_cnt_fo (32), counting cycles with flush_if_fo=1.
  - perf_lu_cnt_fo (16), counting load-use events.
- All three counters are saturating, not wrapping.
- When undefined, these ports and counters are absent and core behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, rs1_used=1 → one cycle of stall_if=stall_id=bubble_ex=1; next cycle (EX now bubble) all 0.
- ex_rd=0 with id_rs1=0 used, load in EX → no stall.
- Redirect with lu also true: target 0x0000_0100 → pc_sel=1, pc_imm=0x100, flush_if=1, bubble_ex=1, stall_if=0.
- Mul/div: md_start at cycle 0, md_done at cycle 4 → stall_if=1 for cycles 0–3, 0 at cycle 4, state RUN at cycle 5.
- Timeout: MD_TIMEOUT=8, md_done never asserted → md_timeout pulses at the 8th stalled cycle, then RUN.
- Halt: halt_req held 3 cycles while MD_WAIT active for 2 → HALT entered after md_done, halted_fo=1 until halt_req drops, then stalls release.
- Reset asserted mid-HALT → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall / flush / redirect controller for the 5-stage RV32IM pipe
//   (IF, ID, EX, MEM, WB). Hazards resolve by fixed priority:
//     branch/jump redirect > mul/div occupancy > load-use > external halt.
//   A registered FSM (RUN, MD_WAIT, HALT) holds the multi-cycle context.
//   All hazard outputs are combinational from that state and the current
//   pipeline inputs.
//
// Parameters
//   DWIDTH      PC / redirect target width.
//   MD_TIMEOUT  max MD_WAIT cycles before a forced exit (2..255).
//
// Ports
//   Clk_Core, Rst_Core      clock, synchronous active-high reset
//   id_rs1/rs2_fi, *_used   ID-stage source registers and their use flags
//   ex_rd_fi, ex_mem_read   EX-stage destination and "is a load" flag
//   ex_branch_taken_fi      EX resolved a taken branch/jump
//   ex_target_fi            redirect target PC
//   ex_md_start_fi          EX issued a multi-cycle mul/div
//   md_done_fi              mul/div result valid
//   halt_req_fi             external halt/debug request (level)
//   stall_if_fo, flush_if_fo, pc_sel_fo, pc_imm_fo   fetch-stage control
//   stall_id_fo, bubble_ex_fo                         decode / ID-EX control
//   md_timeout_fo           one-cycle pulse when MD_WAIT times out
//   halted_fo               pipeline is frozen in HALT
//
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN
//   Adds saturating performance counters perf_stall_cnt_fo (32b),
//   perf_flush_cnt_fo (32b) and perf_lu_cnt_fo (16b), all cleared by reset.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic [4:0]        id_rs1_fi,
  input  logic [4:0]        id_rs2_fi,
  input  logic              id_rs1_used_fi,
  input  logic              id_rs2_used_fi,
  input  logic [4:0]        ex_rd_fi,
  input  logic              ex_mem_read_fi,
  input  logic              ex_branch_taken_fi,
  input  logic [DWIDTH-1:0] ex_target_fi,
  input  logic              ex_md_start_fi,
  input  logic              md_done_fi,
  input  logic              halt_req_fi,
  output logic              stall_if_fo,
  output logic              flush_if_fo,
  output logic              pc_sel_fo,
  output logic [DWIDTH-1:0] pc_imm_fo,
  output logic              stall_id_fo,
  output logic              bubble_ex_fo,
  output logic              md_timeout_fo,
  output logic              halted_fo
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_fo,
  output logic [31:0]       perf_flush_cnt_fo,
  output logic [15:0]       perf_lu_cnt_fo
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  // One extra bit over clog2 so the terminal value never aliases to zero.
  localparam int            CW      = $clog2(MD_TIMEOUT) + 1;
  localparam logic [CW-1:0] MD_LAST = CW'(MD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          lu_block_q, lu_block_d;

  logic          lu_raw;
  logic          lu_hit;
  logic          lu_evt;

  // Combinational hazard outputs before the reset gate.
  logic              stall_if_c, flush_if_c, pc_sel_c, stall_id_c;
  logic              bubble_ex_c, md_timeout_c, halted_c;
  logic [DWIDTH-1:0] pc_imm_c;

  // Load in EX writing a register the ID instruction reads; x0 never hazards.
  assign lu_raw = ex_mem_read_fi & (ex_rd_fi != 5'd0) &
                  ((id_rs1_used_fi & (id_rs1_fi == ex_rd_fi)) |
                   (id_rs2_used_fi & (id_rs2_fi == ex_rd_fi)));

  // After one load-use stall the load has moved on and EX holds the bubble,
  // so the same hazard must not stall a second time.
  assign lu_hit = lu_raw & ~lu_block_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q    <= ST_RUN;
      md_cnt_q   <= '0;
      lu_block_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      lu_block_q <= lu_block_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and hazard outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    lu_block_d   = 1'b0;
    lu_evt       = 1'b0;
    stall_if_c   = 1'b0;
    flush_if_c   = 1'b0;
    pc_sel_c     = 1'b0;
    pc_imm_c     = '0;
    stall_id_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    md_timeout_c = 1'b0;
    halted_c     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken_fi) begin
          // Redirect wins over everything, including a pending load-use:
          // the dependent instruction in ID is being flushed anyway.
          pc_sel_c    = 1'b1;
          pc_imm_c    = ex_target_fi;
          flush_if_c  = 1'b1;
          bubble_ex_c = 1'b1;
          // A simultaneous halt lets the flush land first, then freezes.
          if (halt_req_fi) state_d = ST_HALT;
        end else if (ex_md_start_fi && !md_done_fi) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          state_d    = ST_MD_WAIT;
          md_cnt_d   = '0;
        end else if (lu_hit) begin
          // A mul/div that completes on issue falls through to here.
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
          lu_block_d  = 1'b1;
          lu_evt      = 1'b1;
        end else if (halt_req_fi) begin
          stall_if_c  = 1'b1;
          stall_id_c  = 1'b1;
          bubble_ex_c = 1'b1;
          state_d     = ST_HALT;
        end
      end

      ST_MD_WAIT: begin
        // EX inputs and halt requests are ignored until the unit is released.
        if (md_done_fi) begin
          state_d  = ST_RUN;
          md_cnt_d = '0;
        end else if (md_cnt_q == MD_LAST) begin
          // Give up on the unit; no redirect, the pipe just resumes.
          md_timeout_c = 1'b1;
          state_d      = ST_RUN;
          md_cnt_d     = '0;
        end else begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          md_cnt_d   = md_cnt_q + CNT_ONE;
        end
      end

      ST_HALT: begin
        // Stalls hold for the whole HALT stay; they release in the RUN cycle
        // that follows the request dropping.
        stall_if_c  = 1'b1;
        stall_id_c  = 1'b1;
        bubble_ex_c = 1'b1;
        halted_c    = 1'b1;
        if (!halt_req_fi) state_d = ST_RUN;
      end

      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output gate: everything reads zero while reset is applied.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_if_fo   = stall_if_c   & ~Rst_Core;
    flush_if_fo   = flush_if_c   & ~Rst_Core;
    pc_sel_fo     = pc_sel_c     & ~Rst_Core;
    pc_imm_fo     = Rst_Core ? '0 : pc_imm_c;
    stall_id_fo   = stall_id_c   & ~Rst_Core;
    bubble_ex_fo  = bubble_ex_c  & ~Rst_Core;
    md_timeout_fo = md_timeout_c & ~Rst_Core;
    halted_fo     = halted_c     & ~Rst_Core;
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      perf_stall_cnt_fo <= '0;
      perf_flush_cnt_fo <= '0;
      perf_lu_cnt_fo    <= '0;
    end else begin
      if (stall_if_fo && (perf_stall_cnt_fo != 32'hFFFF_FFFF))
        perf_stall_cnt_fo <= perf_stall_cnt_fo + 32'd1;
      if (flush_if_fo && (perf_flush_cnt_fo != 32'hFFFF_FFFF))
        perf_flush_cnt_fo <= perf_flush_cnt_fo + 32'd1;
      if (lu_evt && (perf_lu_cnt_fo != 16'hFFFF))
        perf_lu_cnt_fo <= perf_lu_cnt_fo + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios with hand-derived expectations, then a randomized run
//   checked cycle by cycle against a behavioural model of the hazard rules.
//   Output vector order: {stall_if, flush_if, pc_sel, stall_id, bubble_ex,
//   md_timeout, halted}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int DW  = 32;
  localparam int MDT = 8;

  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1001100;
  localparam logic [6:0] O_MD   = 7'b1001000;
  localparam logic [6:0] O_BR   = 7'b0110100;
  localparam logic [6:0] O_TO   = 7'b0000010;
  localparam logic [6:0] O_HALT = 7'b1001101;

  logic          Clk_Core = 1'b0;
  logic          Rst_Core;
  logic [4:0]    id_rs1_fi, id_rs2_fi, ex_rd_fi;
  logic          id_rs1_used_fi, id_rs2_used_fi, ex_mem_read_fi;
  logic          ex_branch_taken_fi, ex_md_start_fi, md_done_fi, halt_req_fi;
  logic [DW-1:0] ex_target_fi;
  logic          stall_if_fo, flush_if_fo, pc_sel_fo, stall_id_fo;
  logic          bubble_ex_fo, md_timeout_fo, halted_fo;
  logic [DW-1:0] pc_imm_fo;
  logic [6:0]    outv;

  int tests_run    = 0;
  int tests_failed = 0;

  assign outv = {stall_if_fo, flush_if_fo, pc_sel_fo, stall_id_fo,
                 bubble_ex_fo, md_timeout_fo, halted_fo};

  always #5 Clk_Core = ~Clk_Core;

  pipe_hazard_ctrl #(.DWIDTH(DW), .MD_TIMEOUT(MDT)) dut (
    .Clk_Core(Clk_Core), .Rst_Core(Rst_Core),
    .id_rs1_fi(id_rs1_fi), .id_rs2_fi(id_rs2_fi),
    .id_rs1_used_fi(id_rs1_used_fi), .id_rs2_used_fi(id_rs2_used_fi),
    .ex_rd_fi(ex_rd_fi), .ex_mem_read_fi(ex_mem_read_fi),
    .ex_branch_taken_fi(ex_branch_taken_fi), .ex_target_fi(ex_target_fi),
    .ex_md_start_fi(ex_md_start_fi), .md_done_fi(md_done_fi),
    .halt_req_fi(halt_req_fi),
    .stall_if_fo(stall_if_fo), .flush_if_fo(flush_if_fo),
    .pc_sel_fo(pc_sel_fo), .pc_imm_fo(pc_imm_fo),
    .stall_id_fo(stall_id_fo), .bubble_ex_fo(bubble_ex_fo),
    .md_timeout_fo(md_timeout_fo), .halted_fo(halted_fo)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: md_wait = cycles already spent waiting (-1 = no mul/div
  // outstanding), halted flag, and whether the last cycle was a load-use stall.
  // ---------------------------------------------------------------------------
  int m_md_wait = -1;
  bit m_halted  = 1'b0;
  bit m_lu_prev = 1'b0;

  function automatic bit lu_now();
    return ex_mem_read_fi && (ex_rd_fi != 5'd0) &&
           ((id_rs1_used_fi && id_rs1_fi == ex_rd_fi) ||
            (id_rs2_used_fi && id_rs2_fi == ex_rd_fi)) && !m_lu_prev;
  endfunction

  function automatic logic [6:0] model_out();
    if (Rst_Core) return O_IDLE;
    if (m_md_wait >= 0) begin
      if (md_done_fi) return O_IDLE;
      if (m_md_wait == MDT - 1) return O_TO;
      return O_MD;
    end
    if (m_halted) return O_HALT;
    if (ex_branch_taken_fi) return O_BR;
    if (ex_md_start_fi && !md_done_fi) return O_MD;
    if (lu_now()) return O_LU;
    if (halt_req_fi) return O_LU;  // halt entry stalls and bubbles like lu
    return O_IDLE;
  endfunction

  always @(posedge Clk_Core) begin
    if (Rst_Core) begin
      m_md_wait <= -1; m_halted <= 1'b0; m_lu_prev <= 1'b0;
    end else if (m_md_wait >= 0) begin
      m_lu_prev <= 1'b0;
      if (md_done_fi || m_md_wait == MDT - 1) m_md_wait <= -1;
      else m_md_wait <= m_md_wait + 1;
    end else if (m_halted) begin
      m_lu_prev <= 1'b0;
      if (!halt_req_fi) m_halted <= 1'b0;
    end else begin
      m_lu_prev <= 1'b0;
      if (ex_branch_taken_fi) m_halted <= halt_req_fi;
      else if (ex_md_start_fi && !md_done_fi) m_md_wait <= 0;
      else if (lu_now()) m_lu_prev <= 1'b1;
      else if (halt_req_fi) m_halted <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // ---------------------------------------------------------------------------
  task automatic idle();
    id_rs1_fi = '0; id_rs2_fi = '0; id_rs1_used_fi = 0; id_rs2_used_fi = 0;
    ex_rd_fi = '0; ex_mem_read_fi = 0; ex_branch_taken_fi = 0;
    ex_target_fi = '0; ex_md_start_fi = 0; md_done_fi = 0; halt_req_fi = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic ld);
    ex_rd_fi = rd; id_rs1_fi = rs1; id_rs1_used_fi = u1;
    id_rs2_fi = rs2; id_rs2_used_fi = u2; ex_mem_read_fi = ld;
  endtask

  task automatic tick();
    @(posedge Clk_Core); #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      Rst_Core = 1'b1;
      ex_branch_taken_fi = 1'b1; ex_target_fi = $urandom();
      halt_req_fi = 1'b1; ex_md_start_fi = 1'b1;
      set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== O_IDLE || pc_imm_fo !== '0) begin
        tests_failed++;
        $display("FAIL reset_during[%0d] got %b pc=%h want %b pc=0", i, outv, pc_imm_fo, O_IDLE);
      end
      tick();
    end
    Rst_Core = 1'b0; idle();
    @(negedge Clk_Core);
    tests_run++;
    if (outv !== O_IDLE || pc_imm_fo !== '0) begin
      tests_failed++;
      $display("FAIL reset_after got %b pc=%h want %b pc=0", outv, pc_imm_fo, O_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_v [6] = '{O_LU, O_IDLE, O_IDLE, O_LU, O_IDLE, O_LU};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0:    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);  // rs1 hit
        1:    ;                                            // EX now a bubble
        2:    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);  // x0 never hazards
        3, 4: set_lu(5'd7, 5'd3, 1'b0, 5'd7, 1'b1, 1'b1);  // rs2 hit, held
        5:    set_lu(5'd9, 5'd9, 1'b1, 5'd9, 1'b0, 1'b1);  // new hazard
        default: ;
      endcase
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL load_use[%0d] got %b want %b", i, outv, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [6:0]    exp_v  [6] = '{O_BR, O_IDLE, O_BR, O_HALT, O_HALT, O_IDLE};
    logic [DW-1:0] exp_pc [6];
    logic [DW-1:0] tgt;
    tgt = $urandom() | 32'h1;
    exp_pc = '{32'h0000_0100, 32'h0, tgt, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
                 ex_branch_taken_fi = 1'b1; ex_target_fi = 32'h0000_0100; end
        2: begin ex_branch_taken_fi = 1'b1; ex_target_fi = tgt; halt_req_fi = 1'b1; end
        3: halt_req_fi = 1'b1;
        default: ;
      endcase
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v[i] || pc_imm_fo !== exp_pc[i]) begin
        tests_failed++;
        $display("FAIL redirect[%0d] got %b pc=%h want %b pc=%h", i, outv, pc_imm_fo, exp_v[i], exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_muldiv();
    logic [6:0] exp_v [6] = '{O_MD, O_MD, O_MD, O_MD, O_IDLE, O_LU};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: ex_md_start_fi = 1'b1;
        2: begin ex_branch_taken_fi = 1'b1; ex_target_fi = 32'hDEAD_0000;
                 set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1); end  // ignored
        4: md_done_fi = 1'b1;
        5: set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1);  // RUN again
        default: ;
      endcase
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL muldiv[%0d] got %b want %b", i, outv, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp_v;
    for (int i = 0; i < 11; i++) begin
      idle();
      if (i == 0) ex_md_start_fi = 1'b1;
      if (i == 9) set_lu(5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1);
      exp_v = (i < MDT) ? O_MD : (i == MDT) ? O_TO : (i == 9) ? O_LU : O_IDLE;
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v) begin
        tests_failed++;
        $display("FAIL timeout[%0d] got %b want %b", i, outv, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [6:0] exp_v [6] = '{O_MD, O_MD, O_IDLE, O_LU, O_HALT, O_IDLE};
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: ex_md_start_fi = 1'b1;
        1: halt_req_fi = 1'b1;
        2: begin halt_req_fi = 1'b1; md_done_fi = 1'b1; end
        3: halt_req_fi = 1'b1;
        default: ;
      endcase
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL halt[%0d] got %b want %b", i, outv, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_v [20];
    for (int i = 0; i < 20; i++) exp_v[i] = O_IDLE;
    exp_v[0] = O_LU; exp_v[1] = O_HALT;
    exp_v[4] = O_MD; exp_v[5] = O_MD; exp_v[6] = O_MD; exp_v[19] = O_LU;
    for (int i = 0; i < 20; i++) begin
      idle();
      Rst_Core = (i == 2) || (i == 7);
      case (i)
        0, 1, 2: halt_req_fi = 1'b1;
        4: ex_md_start_fi = 1'b1;
        19: set_lu(5'd1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b1);
        default: ;
      endcase
      @(negedge Clk_Core);
      tests_run++;
      if (outv !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL reset_mid[%0d] got %b want %b", i, outv, exp_v[i]);
      end
      tick();
    end
    Rst_Core = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0]    exp_v;
    logic [DW-1:0] exp_pc;
    Rst_Core = 1'b1; idle(); tick(); tick();
    Rst_Core = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      Rst_Core           = ($urandom_range(0, 199) == 0);
      ex_branch_taken_fi = ($urandom_range(0, 7) == 0);
      ex_target_fi       = $urandom();
      ex_md_start_fi     = ($urandom_range(0, 5) == 0);
      md_done_fi         = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) halt_req_fi = ~halt_req_fi;
      ex_mem_read_fi     = 1'($urandom_range(0, 1));
      ex_rd_fi           = 5'($urandom_range(0, 3));
      id_rs1_fi          = 5'($urandom_range(0, 3));
      id_rs2_fi          = 5'($urandom_range(0, 3));
      id_rs1_used_fi     = 1'($urandom_range(0, 1));
      id_rs2_used_fi     = 1'($urandom_range(0, 1));
      @(negedge Clk_Core);
      exp_v  = model_out();
      exp_pc = exp_v[4] ? ex_target_fi : '0;
      tests_run++;
      if (outv !== exp_v || pc_imm_fo !== exp_pc) begin
        tests_failed++;
        $display("FAIL random[%0d] got %b pc=%h want %b pc=%h", c, outv, pc_imm_fo, exp_v, exp_pc);
      end
      tests_run++;
      if ((stall_if_fo && flush_if_fo) || (pc_sel_fo && !flush_if_fo) ||
          (!pc_sel_fo && pc_imm_fo !== '0)) begin
        tests_failed++;
        $display("FAIL invariant[%0d] got %b pc=%h want consistent stall/flush/pc_sel", c, outv, pc_imm_fo);
      end
      tick();
    end
    Rst_Core = 1'b0; idle();
  endtask

  initial begin
    Rst_Core = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_muldiv();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
